// File: rtl/lcd_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_driver_if
//  Description : Mode/ROM/LCD-bus bundle between lcd_driver and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_driver_if;
    logic [1:0] mode_in;
    logic       ready;
    logic [1:0] rom_mode;
    logic [3:0] rom_cnt;
    logic [7:0] rom_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_db;

    modport master (
        input  mode_in, rom_data,
        output ready, rom_mode, rom_cnt, lcd_e, lcd_rs, lcd_rw, lcd_db
    );

    modport slave (
        output mode_in, rom_data,
        input  ready, rom_mode, rom_cnt, lcd_e, lcd_rs, lcd_rw, lcd_db
    );
endinterface
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_driver
//  Description : HD44780 16x2 driver; runs init, writes the mode title to line 1.
//                Optional macro LCD_REFRESH_EN adds a periodic idle rewrite.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_driver #(
    parameter int TICK_DIV      = 50,
    parameter int POWERUP_TICKS = 400,
    parameter int CLEAR_TICKS   = 40,
    parameter int REFRESH_TICKS = 20000
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_driver_if.master bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] c_cmd_func_set = 8'h38;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_addr     = 8'h80;

    typedef enum logic [3:0] {
        ST_PWR_WAIT = 4'd0,
        ST_FUNC_SET = 4'd1,
        ST_DISP_ON  = 4'd2,
        ST_ENTRY    = 4'd3,
        ST_CLEAR    = 4'd4,
        ST_CLR_WAIT = 4'd5,
        ST_ADDR     = 4'd6,
        ST_WRITE    = 4'd7,
        ST_IDLE     = 4'd8
    } state_t;

    if (TICK_DIV < 1 || POWERUP_TICKS < 1 || POWERUP_TICKS > 65536 ||
        CLEAR_TICKS < 1 || CLEAR_TICKS > 65536 ||
        REFRESH_TICKS < 1 || REFRESH_TICKS > 65536) begin : g_bad_params
        $error("lcd_driver: step counts out of range");
    end

    state_t           r_state, w_state_n;
    logic [1:0]       r_phase, w_phase_n;
    logic [15:0]      r_wait, w_wait_n;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_rewrite;
    logic [1:0]       r_rom_mode, w_rom_mode_n;
    logic [3:0]       r_rom_cnt, w_rom_cnt_n;
    logic             r_lcd_e, w_lcd_e_n;
    logic             r_lcd_rs, w_lcd_rs_n;
    logic [7:0]       r_lcd_db, w_lcd_db_n;
    logic             r_ready, w_ready_n;
`ifdef LCD_REFRESH_EN
    logic [15:0]      r_refresh, w_refresh_n;
`endif

    assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end

    always_comb begin
        w_state_n    = r_state;
        w_phase_n    = r_phase;
        w_wait_n     = r_wait;
        w_rom_mode_n = r_rom_mode;
        w_rom_cnt_n  = r_rom_cnt;
        w_lcd_e_n    = r_lcd_e;
        w_lcd_rs_n   = r_lcd_rs;
        w_lcd_db_n   = r_lcd_db;
        w_ready_n    = r_ready;
        w_rewrite    = 1'b0;
`ifdef LCD_REFRESH_EN
        w_refresh_n  = r_refresh;
`endif
        // rom_cnt only advances at the S0 boundary, so the new character is
        // picked up during S0 and is settled before E rises.
        if (r_state == ST_WRITE && r_phase == 2'd0)
            w_lcd_db_n = bus.rom_data;

        if (w_tick) begin
            case (r_state)
                ST_PWR_WAIT: begin
                    if (r_wait == 16'(POWERUP_TICKS - 1)) begin
                        w_wait_n   = '0;
                        w_state_n  = ST_FUNC_SET;
                        w_lcd_rs_n = 1'b0;
                        w_lcd_db_n = c_cmd_func_set;
                    end else begin
                        w_wait_n = r_wait + 16'd1;
                    end
                end
                ST_CLR_WAIT: begin
                    if (r_wait == 16'(CLEAR_TICKS - 1)) begin
                        w_wait_n     = '0;
                        w_state_n    = ST_ADDR;
                        w_lcd_rs_n   = 1'b0;
                        w_lcd_db_n   = c_cmd_addr;
                        w_rom_cnt_n  = '0;
                        w_rom_mode_n = bus.mode_in;
                    end else begin
                        w_wait_n = r_wait + 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.mode_in != r_rom_mode) begin
                        w_rom_mode_n = bus.mode_in;
                        w_rewrite    = 1'b1;
                    end
`ifdef LCD_REFRESH_EN
                    else if (r_refresh == 16'(REFRESH_TICKS - 1)) begin
                        w_rewrite = 1'b1;
                    end
                    w_refresh_n = w_rewrite ? 16'd0 : r_refresh + 16'd1;
`endif
                    if (w_rewrite) begin
                        w_ready_n   = 1'b0;
                        w_state_n   = ST_ADDR;
                        w_lcd_rs_n  = 1'b0;
                        w_lcd_db_n  = c_cmd_addr;
                        w_rom_cnt_n = '0;
                    end
                end
                default: begin
                    // Byte-write states: S0 setup, S1 E high, S2 hold.
                    case (r_phase)
                        2'd0: begin
                            w_phase_n = 2'd1;
                            w_lcd_e_n = 1'b1;
                        end
                        2'd1: begin
                            w_phase_n = 2'd2;
                            w_lcd_e_n = 1'b0;
                        end
                        default: begin
                            w_phase_n = 2'd0;
                            case (r_state)
                                ST_FUNC_SET: begin
                                    w_state_n  = ST_DISP_ON;
                                    w_lcd_db_n = c_cmd_disp_on;
                                end
                                ST_DISP_ON: begin
                                    w_state_n  = ST_ENTRY;
                                    w_lcd_db_n = c_cmd_entry;
                                end
                                ST_ENTRY: begin
                                    w_state_n  = ST_CLEAR;
                                    w_lcd_db_n = c_cmd_clear;
                                end
                                ST_CLEAR: begin
                                    w_state_n = ST_CLR_WAIT;
                                end
                                ST_ADDR: begin
                                    w_state_n  = ST_WRITE;
                                    w_lcd_rs_n = 1'b1;
                                    w_lcd_db_n = bus.rom_data;
                                end
                                ST_WRITE: begin
                                    if (r_rom_cnt == 4'd15) begin
                                        w_state_n   = ST_IDLE;
                                        w_rom_cnt_n = '0;
                                        w_ready_n   = 1'b1;
                                    end else begin
                                        w_rom_cnt_n = r_rom_cnt + 4'd1;
                                    end
                                end
                                default: begin
                                    w_state_n = ST_PWR_WAIT;
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_PWR_WAIT;
            r_phase    <= 2'd0;
            r_wait     <= '0;
            r_rom_mode <= 2'b00;
            r_rom_cnt  <= '0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_db   <= '0;
            r_ready    <= 1'b0;
`ifdef LCD_REFRESH_EN
            r_refresh  <= '0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_phase    <= w_phase_n;
            r_wait     <= w_wait_n;
            r_rom_mode <= w_rom_mode_n;
            r_rom_cnt  <= w_rom_cnt_n;
            r_lcd_e    <= w_lcd_e_n;
            r_lcd_rs   <= w_lcd_rs_n;
            r_lcd_db   <= w_lcd_db_n;
            r_ready    <= w_ready_n;
`ifdef LCD_REFRESH_EN
            r_refresh  <= w_refresh_n;
`endif
        end
    end

    assign bus.rom_mode = r_rom_mode;
    assign bus.rom_cnt  = r_rom_cnt;
    assign bus.lcd_e    = r_lcd_e;
    assign bus.lcd_rs   = r_lcd_rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_db   = r_lcd_db;
    assign bus.ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_driver
//  Description : Directed bench for lcd_driver with a title ROM and bus logger.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_driver;
    localparam int TICK_DIV = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    lcd_driver_if bus ();

    lcd_driver #(
        .TICK_DIV      (TICK_DIV),
        .POWERUP_TICKS (4),
        .CLEAR_TICKS   (3),
        .REFRESH_TICKS (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] rom_char(input logic [1:0] m, input logic [3:0] c);
        logic [127:0] s;
        case (m)
            2'b00:   s = "MODE1: WATCH    ";
            2'b01:   s = "MODE2: ALARM    ";
            2'b10:   s = "MODE3: STOPWATCH";
            default: s = "MODE4: SET      ";
        endcase
        return s[8*(15-int'(c)) +: 8];
    endfunction

    assign bus.rom_data = rom_char(bus.rom_mode, bus.rom_cnt);

    // Every completed E pulse is a byte the LCD latched: {rs, db}
    logic [8:0] lcd_log[$];
    initial forever begin
        @(negedge bus.lcd_e);
        lcd_log.push_back({bus.lcd_rs, bus.lcd_db});
    end

    int         e_hi, s2_left, timing_bad, e_pulses;
    logic [8:0] held;
    initial begin
        e_hi = 0; s2_left = 0; timing_bad = 0; e_pulses = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                e_hi = 0;
                s2_left = 0;
            end else begin
                if (bus.lcd_rw !== 1'b0) timing_bad++;
                if (bus.lcd_e === 1'b1) begin
                    if (e_hi == 0) held = {bus.lcd_rs, bus.lcd_db};
                    else if ({bus.lcd_rs, bus.lcd_db} !== held) timing_bad++;
                    e_hi++;
                    s2_left = 0;
                end else begin
                    if (e_hi != 0) begin
                        if (e_hi != TICK_DIV) timing_bad++;
                        e_pulses++;
                        e_hi = 0;
                        s2_left = TICK_DIV;
                    end
                    if (s2_left > 0) begin
                        if ({bus.lcd_rs, bus.lcd_db} !== held) timing_bad++;
                        s2_left--;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_q[$];
    int         log_base = 0;

    task automatic expect_cmd(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask

    task automatic expect_title(input logic [1:0] m);
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, rom_char(m, 4'(c))});
    endtask

    task automatic expect_init();
        expect_cmd(8'h38); expect_cmd(8'h0C); expect_cmd(8'h06); expect_cmd(8'h01);
    endtask

    task automatic compare_log(input string tag);
        int n;
        n = lcd_log.size() - log_base;
        check({tag, " count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s byte%0d", tag, i), lcd_log[log_base+i], exp_q[i]);
        exp_q.delete();
        log_base = lcd_log.size();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (bus.ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.ready, 1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int n = 0;
        while (bus.ready !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.mode_in = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst lcd_e", bus.lcd_e, 0);
        check("rst lcd_rs", bus.lcd_rs, 0);
        check("rst lcd_db", bus.lcd_db, 0);
        check("rst ready", bus.ready, 0);
        check("rst rom_cnt", bus.rom_cnt, 0);
        check("rst rom_mode", bus.rom_mode, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        log_base = lcd_log.size();

        // Reset last sampled at clk 2: 4 power-up steps + S0 puts the first E rise at clk 12
        n = 0;
        while (bus.lcd_e !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first E rise clk", cyc, 12);

        wait_ready("init ready", 2000);
        expect_init(); expect_cmd(8'h80); expect_title(2'b00);
        compare_log("init");
        check("idle rom_cnt", bus.rom_cnt, 0);

        // Mode change from IDLE: address + new title, no clear
        @(negedge clk);
        bus.mode_in = 2'b01;
        wait_busy("alarm busy", TICK_DIV + 1);
        wait_ready("alarm ready", 1000);
        expect_cmd(8'h80); expect_title(2'b01);
        compare_log("alarm");
        check("alarm rom_mode", bus.rom_mode, 1);

        // Toggles during WRITE are deferred; only the value present in IDLE counts
        @(negedge clk);
        bus.mode_in = 2'b00;
        n = 0;
        while (bus.rom_cnt !== 4'd5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mix reach cnt5", bus.rom_cnt, 5);
        bus.mode_in = 2'b10;
        repeat (3) @(negedge clk);
        bus.mode_in = 2'b11;
        wait_ready("mix first ready", 1000);
        check("mix latched", bus.rom_mode, 0);
        wait_busy("mix rebusy", TICK_DIV + 1);
        wait_ready("mix second ready", 1000);
        expect_cmd(8'h80); expect_title(2'b00);
        expect_cmd(8'h80); expect_title(2'b11);
        compare_log("mix");

        // Reset in the middle of a title write
        @(negedge clk);
        bus.mode_in = 2'b10;
        n = 0;
        while (!(bus.rom_cnt === 4'd7 && bus.lcd_e === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort reach cnt7 e1", {bus.rom_cnt, bus.lcd_e}, {4'd7, 1'b1});
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort lcd_e", bus.lcd_e, 0);
        check("abort rom_cnt", bus.rom_cnt, 0);
        check("abort ready", bus.ready, 0);
        check("abort rom_mode", bus.rom_mode, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        log_base = lcd_log.size();
        wait_ready("reinit ready", 2000);
        expect_init(); expect_cmd(8'h80); expect_title(2'b10);
        compare_log("reinit");

`ifdef LCD_REFRESH_EN
        wait_busy("refresh start", 30);
        wait_ready("refresh ready", 1000);
        expect_cmd(8'h80); expect_title(2'b10);
        compare_log("refresh");
`else
        repeat (40) @(negedge clk);
        check("idle quiet bytes", lcd_log.size() - log_base, 0);
        check("idle quiet ready", bus.ready, 1);
`endif

        check("bus timing violations", timing_bad, 0);
        check("E pulses observed", e_pulses >= 90, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
